// File: rtl/neo_d0_wr_if.sv
// Request/response and NEO-D0 bus signals of the 68k-side write initiator.
// The write initiator uses the slave view; whatever issues writes uses the master view.
interface neo_d0_wr_if;
  logic       REQ;
  logic       READY;
  logic       SEL_BANK;
  logic [5:0] WDATA;
  logic       DONE;
  logic       M68K_ADDR_A4;
  logic [5:0] M68K_DATA;
  logic       nBITWD0;
  logic [2:0] BNK_SH;
  logic [2:0] P1_SH;
  logic [2:0] P2_SH;

  modport slave (
    input  REQ, SEL_BANK, WDATA,
    output READY, DONE, M68K_ADDR_A4, M68K_DATA, nBITWD0, BNK_SH, P1_SH, P2_SH
  );

  modport master (
    output REQ, SEL_BANK, WDATA,
    input  READY, DONE, M68K_ADDR_A4, M68K_DATA, nBITWD0, BNK_SH, P1_SH, P2_SH
  );
endinterface

// File: rtl/neo_d0_wr.sv
// Write initiator for NEO-D0 REG_POUTPUT / REG_CRDBANK: sequences A4, DATA and the
// nBITWD0 strobe with programmable setup/low/hold, and shadows the write-only registers.
module neo_d0_wr #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned LOW_CYC   = 4,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic           CLK_24M,
  input  logic           RESET,
  neo_d0_wr_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] LOW_LD   = 4'(LOW_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       nbit_q, nbit_d;
  logic       a4_q, a4_d;
  logic [5:0] data_q, data_d;
  logic [2:0] bnk_q, bnk_d;
  logic [2:0] p1_q, p1_d;
  logic [2:0] p2_q, p2_d;

  always_comb begin
    // NOTE: every next-state signal is defaulted before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    nbit_d  = nbit_q;
    a4_d    = a4_q;
    data_d  = data_q;
    bnk_d   = bnk_q;
    p1_d    = p1_q;
    p2_d    = p2_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        // READY is still low on the first edge after reset, so nothing is taken there.
        if (bus.REQ && ready_q) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          ready_d = 1'b0;
          a4_d    = bus.SEL_BANK;
          data_d  = bus.WDATA;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = LOW_LD;
          nbit_d  = 1'b0;
          // Shadows follow the falling strobe edge, which is where NEO-D0 latches.
          if (a4_q) bnk_d = data_q[2:0];
          else      {p2_d, p1_d} = data_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          nbit_d  = 1'b1;
          done_d  = (HOLD_CYC == 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          done_d = (cnt_q == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      nbit_q  <= 1'b1;
      a4_q    <= 1'b0;
      data_q  <= 6'd0;
      bnk_q   <= 3'd0;
      p1_q    <= 3'd0;
      p2_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      nbit_q  <= nbit_d;
      a4_q    <= a4_d;
      data_q  <= data_d;
      bnk_q   <= bnk_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  assign bus.READY        = ready_q;
  assign bus.DONE         = done_q;
  assign bus.nBITWD0      = nbit_q;
  assign bus.M68K_ADDR_A4 = a4_q;
  assign bus.M68K_DATA    = data_q;
  assign bus.BNK_SH       = bnk_q;
  assign bus.P1_SH        = p1_q;
  assign bus.P2_SH        = p2_q;

endmodule

// File: tb/tb_neo_d0_wr.sv
// Directed bench for neo_d0_wr: default timing plus 1/1/1 and 15/15/15 instances side by side.
// Cycle 1 is the cycle in which a request is presented; later cycles are counted from there.
module tb_neo_d0_wr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neo_d0_wr_if if0 ();
  neo_d0_wr_if if1 ();
  neo_d0_wr_if if2 ();

  neo_d0_wr #(.SETUP_CYC(2),  .LOW_CYC(4),  .HOLD_CYC(2))  u_dut0 (.CLK_24M(clk), .RESET(rst), .bus(if0.slave));
  neo_d0_wr #(.SETUP_CYC(1),  .LOW_CYC(1),  .HOLD_CYC(1))  u_dut1 (.CLK_24M(clk), .RESET(rst), .bus(if1.slave));
  neo_d0_wr #(.SETUP_CYC(15), .LOW_CYC(15), .HOLD_CYC(15)) u_dut2 (.CLK_24M(clk), .RESET(rst), .bus(if2.slave));

  int s_cyc [3] = '{2, 1, 15};
  int l_cyc [3] = '{4, 1, 15};
  int h_cyc [3] = '{2, 1, 15};

  int n_checks = 0;
  int n_errors = 0;

  int   first_low [3];
  int   low_cnt   [3];
  int   done_cyc  [3];
  int   done_cnt  [3];
  int   ready_cyc [3];
  int   busy      [3];
  logic bus_ok;

  int   falls, fall1, fall2, rdy_cnt, dn_cnt, low_seen;
  logic prev_nb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic sel, input logic [5:0] data);
    if0.REQ = req[0]; if1.REQ = req[1]; if2.REQ = req[2];
    if0.SEL_BANK = sel; if1.SEL_BANK = sel; if2.SEL_BANK = sel;
    if0.WDATA = data;   if1.WDATA = data;   if2.WDATA = data;
  endtask

  // Presents one request in the current cycle, then records strobe/DONE/READY timing per instance.
  task automatic run_write(input logic [2:0] which, input logic sel, input logic [5:0] data, input int ncyc);
    logic [2:0] nb, rd, dn;
    drive(which, sel, data);
    for (int k = 0; k < 3; k++) begin
      first_low[k] = -1; low_cnt[k] = 0; done_cyc[k] = -1;
      done_cnt[k] = 0;   ready_cyc[k] = -1; busy[k] = 0;
    end
    bus_ok = 1'b1;
    for (int c = 2; c <= ncyc; c++) begin
      @(negedge clk);
      nb = {if2.nBITWD0, if1.nBITWD0, if0.nBITWD0};
      rd = {if2.READY,   if1.READY,   if0.READY};
      dn = {if2.DONE,    if1.DONE,    if0.DONE};
      for (int k = 0; k < 3; k++) begin
        if (!nb[k]) begin
          low_cnt[k]++;
          if (first_low[k] < 0) first_low[k] = c;
        end
        if (dn[k]) begin
          done_cnt[k]++;
          done_cyc[k] = c;
        end
        if (!rd[k]) busy[k]++;
        else if (ready_cyc[k] < 0) ready_cyc[k] = c;
      end
      if (!rd[0] && (if0.M68K_ADDR_A4 !== sel || if0.M68K_DATA !== data)) bus_ok = 1'b0;
      // Scramble inputs right after acceptance; the write must not notice.
      if (c == 2) drive(3'b000, ~sel, ~data);
    end
  endtask

  task automatic check_timing(input string t, input int k);
    int sum;
    sum = s_cyc[k] + l_cyc[k] + h_cyc[k];
    check($sformatf("%s_u%0d_first_low", t, k), first_low[k], s_cyc[k] + 2);
    check($sformatf("%s_u%0d_low_cnt",   t, k), low_cnt[k],   l_cyc[k]);
    check($sformatf("%s_u%0d_done_cyc",  t, k), done_cyc[k],  sum + 1);
    check($sformatf("%s_u%0d_done_cnt",  t, k), done_cnt[k],  1);
    check($sformatf("%s_u%0d_busy",      t, k), busy[k],      sum);
    check($sformatf("%s_u%0d_ready_cyc", t, k), ready_cyc[k], sum + 2);
  endtask

  initial begin
    // 1. Reset held three edges with REQ also high: reset wins.
    rst = 1'b1;
    drive(3'b111, 1'b1, 6'h2A);
    repeat (3) @(negedge clk);
    check("t1_nbit",  if0.nBITWD0, 1);
    check("t1_a4",    if0.M68K_ADDR_A4, 0);
    check("t1_data",  if0.M68K_DATA, 0);
    check("t1_bnk",   if0.BNK_SH, 0);
    check("t1_p1",    if0.P1_SH, 0);
    check("t1_p2",    if0.P2_SH, 0);
    check("t1_ready", if0.READY, 0);
    check("t1_done",  if0.DONE, 0);
    rst = 1'b0;
    drive(3'b000, 1'b0, 6'h00);
    @(negedge clk);
    check("t1_ready_after", if0.READY, 1);
    check("t1_ready_after_u2", if2.READY, 1);
    check("t1_nbit_after", if0.nBITWD0, 1);

    // 2. POUTPUT write 1C on all instances.
    run_write(3'b111, 1'b0, 6'h1C, 50);
    for (int k = 0; k < 3; k++) check_timing("t2", k);
    check("t2_bus_stable", bus_ok, 1);
    check("t2_p2",   if0.P2_SH, 3);
    check("t2_p1",   if0.P1_SH, 4);
    check("t2_bnk",  if0.BNK_SH, 0);
    check("t2_a4",   if0.M68K_ADDR_A4, 0);
    check("t2_data", if0.M68K_DATA, 6'h1C);

    // 3. Bank write 3F: A4=1, only BNK shadow moves.
    run_write(3'b111, 1'b1, 6'h3F, 50);
    for (int k = 0; k < 3; k++) check_timing("t3", k);
    check("t3_bus_stable", bus_ok, 1);
    check("t3_bnk",  if0.BNK_SH, 7);
    check("t3_p1",   if0.P1_SH, 4);
    check("t3_p2",   if0.P2_SH, 3);
    check("t3_a4",   if0.M68K_ADDR_A4, 1);
    check("t3_data", if0.M68K_DATA, 6'h3F);
    check("t3_u1_bnk", if1.BNK_SH, 7);
    check("t3_u2_bnk", if2.BNK_SH, 7);

    // 4. REQ held high across two writes: POUTPUT 1C then bank 05.
    drive(3'b001, 1'b0, 6'h1C);
    falls = 0; fall1 = -1; fall2 = -1; rdy_cnt = 0; prev_nb = 1'b1;
    for (int c = 2; c <= 22; c++) begin
      @(negedge clk);
      if (prev_nb && !if0.nBITWD0) begin
        falls++;
        if (fall1 < 0) fall1 = c;
        else           fall2 = c;
      end
      prev_nb = if0.nBITWD0;
      if (c <= 18 && if0.READY) rdy_cnt++;
      if (c == 2)  drive(3'b001, 1'b1, 6'h05);
      if (c == 11) drive(3'b000, 1'b1, 6'h05);
    end
    check("t4_strobes", falls, 2);
    check("t4_fall1",   fall1, 4);
    check("t4_fall2",   fall2, 13);
    check("t4_idle_gap", rdy_cnt, 1);
    check("t4_bnk",  if0.BNK_SH, 5);
    check("t4_p1",   if0.P1_SH, 4);
    check("t4_p2",   if0.P2_SH, 3);
    check("t4_a4",   if0.M68K_ADDR_A4, 1);
    check("t4_data", if0.M68K_DATA, 6'h05);

    // 4b. A REQ pulse in the middle of a write is dropped, not queued.
    drive(3'b001, 1'b0, 6'h2A);
    falls = 0; prev_nb = 1'b1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (prev_nb && !if0.nBITWD0) falls++;
      prev_nb = if0.nBITWD0;
      if (c == 2) drive(3'b000, 1'b0, 6'h2A);
      if (c == 5) drive(3'b001, 1'b1, 6'h07);
      if (c == 6) drive(3'b000, 1'b0, 6'h00);
    end
    check("t4b_strobes", falls, 1);
    check("t4b_p2",    if0.P2_SH, 5);
    check("t4b_p1",    if0.P1_SH, 2);
    check("t4b_bnk",   if0.BNK_SH, 5);
    check("t4b_data",  if0.M68K_DATA, 6'h2A);
    check("t4b_ready", if0.READY, 1);

    // 5. Reset during the second STROBE cycle.
    drive(3'b001, 1'b0, 6'h15);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) drive(3'b000, 1'b0, 6'h15);
    end
    check("t5_strobing", if0.nBITWD0, 0);
    check("t5_p1_latched", if0.P1_SH, 5);
    rst = 1'b1;
    @(negedge clk);
    check("t5_nbit",  if0.nBITWD0, 1);
    check("t5_a4",    if0.M68K_ADDR_A4, 0);
    check("t5_data",  if0.M68K_DATA, 0);
    check("t5_bnk",   if0.BNK_SH, 0);
    check("t5_p1",    if0.P1_SH, 0);
    check("t5_p2",    if0.P2_SH, 0);
    check("t5_ready", if0.READY, 0);
    check("t5_done",  if0.DONE, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", if0.READY, 1);
    dn_cnt = 0; low_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if0.DONE) dn_cnt++;
      if (!if0.nBITWD0) low_seen++;
    end
    check("t5_no_done",  dn_cnt, 0);
    check("t5_no_strobe", low_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
